// File: rtl/bsg_cgol_pkg.sv
// Shared types and helpers for the Game-of-Life sequence controller.
//   state_e     : controller FSM states (idle, running, inter-generation gap, result held)
//   mode_e      : latched game mode (free-run or single-step)
//   safe_clog2  : ceil(log2(x)) that never returns less than 1, for sizing counters
package bsg_cgol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_e;

    typedef enum logic {
        MODE_FREE_RUN,
        MODE_STEP
    } mode_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_cgol_frame_counter.sv
// Generation bookkeeping for one game: remaining generations, generations applied,
// and the idle-cycle counter used between generation pulses.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_load          : start of game; load i_frames, clear applied count
//   i_frames        : requested generation count
//   i_fire          : one generation applied this cycle
//   i_gap_tick      : one unpaused gap cycle elapsed
//   o_frames_done   : generations applied so far
//   o_last_frame    : the next fire consumes the final remaining generation
//   o_gap_last      : the current gap tick is the final one
module bsg_cgol_frame_counter
    import bsg_cgol_pkg::*;
#(
    parameter int len_width_p  = 11,
    parameter int gap_cycles_p = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [len_width_p-1:0] i_frames,
    input  logic                   i_fire,
    input  logic                   i_gap_tick,
    output logic [len_width_p-1:0] o_frames_done,
    output logic                   o_last_frame,
    output logic                   o_gap_last
);

    localparam int gap_width_lp = safe_clog2(gap_cycles_p + 1);
    // With no gap configured the gap counter is never ticked; the compare value is moot.
    localparam int gap_last_lp  = (gap_cycles_p > 0) ? gap_cycles_p - 1 : 0;

    logic [len_width_p-1:0]  r_remaining;
    logic [len_width_p-1:0]  r_done;
    logic [gap_width_lp-1:0] r_gap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_remaining <= '0;
            r_done      <= '0;
            r_gap       <= '0;
        end else if (i_load) begin
            r_remaining <= i_frames;
            r_done      <= '0;
            r_gap       <= '0;
        end else if (i_fire) begin
            r_remaining <= r_remaining - len_width_p'(1);
            r_done      <= r_done + len_width_p'(1);
            r_gap       <= '0;
        end else if (i_gap_tick) begin
            r_gap <= o_gap_last ? '0 : r_gap + gap_width_lp'(1);
        end
    end

    assign o_frames_done = r_done;
    assign o_last_frame  = (r_remaining == len_width_p'(1));
    assign o_gap_last    = (r_gap == gap_width_lp'(gap_last_lp));

endmodule

// File: rtl/bsg_cgol_seq_ctrl.sv
// Sequencing controller for a Game-of-Life cell array: accepts a game request,
// loads the board, then issues generation pulses (free-running with optional
// spacing, or one per step request) until the requested count is reached, the
// array reports stability, or the game is aborted. The result is held until consumed.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   en_i            : global enable; low freezes all state and gates ready_o/en_o/update_o
//   frames_i, step_mode_i, v_i / ready_o : game request handshake
//   step_i          : single-step advance (step mode, RUN only)
//   pause_i         : hold generation in free-run
//   abort_i         : cancel the current game without a result
//   stable_i        : cell array did not change on its last generation
//   v_o, frames_done_o / yumi_i : result handshake
//   update_o        : load input board into cell array
//   en_o            : advance cell array one generation
module bsg_cgol_seq_ctrl
    import bsg_cgol_pkg::*;
#(
    parameter  int max_game_length_p = 1024,
    parameter  int gap_cycles_p      = 0,
    localparam int game_len_width_lp = safe_clog2(max_game_length_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         en_i,
    input  logic [game_len_width_lp-1:0] frames_i,
    input  logic                         step_mode_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic                         step_i,
    input  logic                         pause_i,
    input  logic                         abort_i,
    input  logic                         stable_i,
    input  logic                         yumi_i,
    output logic                         v_o,
    output logic [game_len_width_lp-1:0] frames_done_o,
    output logic                         update_o,
    output logic                         en_o
);

    state_e r_state;
    mode_e  r_mode;

    logic w_free_paused;
    logic w_fire;
    logic w_gap_tick;
    logic w_last_frame;
    logic w_gap_last;

    // reset_ni gates ready_o so it stays low during reset even though the
    // state already reads IDLE, and rises as soon as reset is released.
    assign ready_o       = reset_ni & en_i & (r_state == ST_IDLE);
    assign update_o      = ready_o & v_i;
    assign v_o           = (r_state == ST_DONE);
    assign w_free_paused = (r_mode == MODE_FREE_RUN) & pause_i;

    // abort and stable both pre-empt a generation pulse in the same cycle.
    assign w_fire     = en_i & (r_state == ST_RUN) & ~abort_i & ~stable_i &
                        ((r_mode == MODE_STEP) ? step_i : ~pause_i);
    assign w_gap_tick = en_i & (r_state == ST_GAP) & ~abort_i & ~stable_i & ~w_free_paused;
    assign en_o       = w_fire;

    bsg_cgol_frame_counter #(
        .len_width_p  (game_len_width_lp),
        .gap_cycles_p (gap_cycles_p)
    ) u_counter (
        .i_clk         (clk_i),
        .i_rst_n       (reset_ni),
        .i_load        (update_o),
        .i_frames      (frames_i),
        .i_fire        (w_fire),
        .i_gap_tick    (w_gap_tick),
        .o_frames_done (frames_done_o),
        .o_last_frame  (w_last_frame),
        .o_gap_last    (w_gap_last)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_FREE_RUN;
        end else if (en_i) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (v_i) begin
                        r_mode  <= step_mode_i ? MODE_STEP : MODE_FREE_RUN;
                        r_state <= (frames_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        r_state <= ST_IDLE;
                    end else if (stable_i) begin
                        r_state <= ST_DONE;
                    end else if (w_fire) begin
                        if (w_last_frame) begin
                            r_state <= ST_DONE;
                        end else if (gap_cycles_p > 0) begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort_i) begin
                        r_state <= ST_IDLE;
                    end else if (stable_i) begin
                        r_state <= ST_DONE;
                    end else if (w_gap_tick && w_gap_last) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (yumi_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_cgol_seq_ctrl.sv
module tb_bsg_cgol_seq_ctrl;

    localparam int GAP = 2;
    localparam int W   = 11;

    logic         clk = 1'b0;
    logic         reset_ni, en_i, step_mode_i, v_i, step_i, pause_i, abort_i, stable_i, yumi_i;
    logic [W-1:0] frames_i;
    logic         ready_o, v_o, update_o, en_o;
    logic [W-1:0] frames_done_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    // Reference model: a game is either in progress (busy) or holding a result;
    // 'cool' counts unpaused idle cycles still owed before the next generation.
    bit m_busy, m_res, m_stepm;
    int m_left, m_applied, m_cool;

    int en_cnt, upd_cnt, n_steps, snap;
    int en_times[$];

    always #5 clk = ~clk;

    bsg_cgol_seq_ctrl #(
        .max_game_length_p (1024),
        .gap_cycles_p      (GAP)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .en_i          (en_i),
        .frames_i      (frames_i),
        .step_mode_i   (step_mode_i),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .step_i        (step_i),
        .pause_i       (pause_i),
        .abort_i       (abort_i),
        .stable_i      (stable_i),
        .yumi_i        (yumi_i),
        .v_o           (v_o),
        .frames_done_o (frames_done_o),
        .update_o      (update_o),
        .en_o          (en_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic idle_inputs();
        reset_ni = 1'b1; en_i = 1'b1; frames_i = '0; step_mode_i = 1'b0; v_i = 1'b0;
        step_i = 1'b0; pause_i = 1'b0; abort_i = 1'b0; stable_i = 1'b0; yumi_i = 1'b0;
    endtask

    task automatic clear_obs();
        en_cnt = 0; upd_cnt = 0; en_times.delete();
    endtask

    // Entered at a falling edge with inputs already applied: compare, clock, advance model.
    task automatic cycle();
        bit running, gapping, e_ready, e_v, e_upd, e_en;
        #2;
        if (!reset_ni) begin
            m_busy = 0; m_res = 0; m_stepm = 0; m_left = 0; m_applied = 0; m_cool = 0;
        end
        running = m_busy && (m_cool == 0);
        gapping = m_busy && (m_cool > 0);
        e_ready = reset_ni && en_i && !m_busy && !m_res;
        e_v     = m_res;
        e_upd   = e_ready && v_i;
        e_en    = reset_ni && en_i && running && !abort_i && !stable_i &&
                  (m_stepm ? step_i : !pause_i);
        chk("ready_o", ready_o, e_ready);
        chk("v_o", v_o, e_v);
        chk("update_o", update_o, e_upd);
        chk("en_o", en_o, e_en);
        chk("upd_en_exclusive", update_o & en_o, 0);
        if (e_v || !reset_ni) chk("frames_done_o", frames_done_o, m_applied);
        if (en_o === 1'b1) begin en_cnt++; en_times.push_back(cyc_n); end
        if (update_o === 1'b1) upd_cnt++;
        @(posedge clk);
        if (reset_ni && en_i) begin
            if (e_upd) begin
                m_applied = 0; m_left = int'(frames_i); m_stepm = step_mode_i; m_cool = 0;
                if (frames_i == 0) m_res = 1; else m_busy = 1;
            end else if (m_busy && abort_i) begin
                m_busy = 0;
            end else if (m_busy && stable_i) begin
                m_busy = 0; m_res = 1;
            end else if (e_en) begin
                m_applied++; m_left--;
                if (m_left == 0) begin m_busy = 0; m_res = 1; end
                else m_cool = GAP;
            end else if (gapping && (m_stepm || !pause_i)) begin
                m_cool--;
            end else if (m_res && yumi_i) begin
                m_res = 0;
            end
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic start_game(input int frames, input bit stepm);
        v_i = 1'b1; frames_i = W'(frames); step_mode_i = stepm;
        cycle();
        v_i = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int budget);
        for (int k = 0; k < budget && v_o !== 1'b1; k++) cycle();
        chk(tag, v_o, 1);
    endtask

    task automatic consume();
        yumi_i = 1'b1; cycle(); yumi_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset_ni = 1'b0;
        #1;
        chk("rst_ready", ready_o, 0);
        chk("rst_v", v_o, 0);
        chk("rst_fd", frames_done_o, 0);
        chk("rst_en", en_o, 0);
        chk("rst_upd", update_o, 0);
        @(negedge clk);
        repeat (3) cycle();
        reset_ni = 1'b1;
        #1;
        chk("ready_after_reset", ready_o, 1);
        cycle();

        // Free-run, 5 generations, spacing gap+1
        clear_obs();
        start_game(5, 1'b0);
        wait_result("t23_result", 40);
        chk("t23_en_count", en_cnt, 5);
        chk("t23_upd_count", upd_cnt, 1);
        for (int i = 1; i < en_times.size(); i++)
            chk("t23_spacing", en_times[i] - en_times[i-1], GAP + 1);
        chk("t23_fd", frames_done_o, 5);
        consume();
        chk("t23_ready_back", ready_o, 1);

        // Zero-length game
        clear_obs();
        start_game(0, 1'b0);
        chk("t24_v_next", v_o, 1);
        chk("t24_fd", frames_done_o, 0);
        chk("t24_upd_count", upd_cnt, 1);
        cycle();
        chk("t24_no_en", en_cnt, 0);
        consume();

        // Step mode, 3 generations, random step spacing and pause toggling
        clear_obs();
        n_steps = 0;
        start_game(3, 1'b1);
        for (int k = 0; k < 10 && v_o !== 1'b1; k++) begin
            step_i = 1'b1; pause_i = 1'($urandom_range(1));
            cycle();
            n_steps++;
            step_i = 1'b0;
            repeat (3 + $urandom_range(4)) begin
                pause_i = 1'($urandom_range(1));
                cycle();
            end
        end
        pause_i = 1'b0;
        chk("t25_result", v_o, 1);
        chk("t25_steps", n_steps, 3);
        chk("t25_en_count", en_cnt, 3);
        chk("t25_fd", frames_done_o, 3);
        consume();

        // Stability after the 4th generation of 10
        clear_obs();
        start_game(10, 1'b0);
        for (int k = 0; k < 60 && en_cnt < 4; k++) cycle();
        chk("t26_reach4", en_cnt, 4);
        stable_i = 1'b1; cycle(); stable_i = 1'b0;
        repeat (4) cycle();
        chk("t26_no_more_en", en_cnt, 4);
        chk("t26_result", v_o, 1);
        chk("t26_fd", frames_done_o, 4);
        consume();

        // Abort together with stable: silent return to idle
        clear_obs();
        start_game(10, 1'b0);
        repeat (2) cycle();
        abort_i = 1'b1; stable_i = 1'b1; cycle(); abort_i = 1'b0; stable_i = 1'b0;
        snap = en_cnt;
        repeat (5) cycle();
        chk("t26_abort_no_v", v_o, 0);
        chk("t26_abort_ready", ready_o, 1);
        chk("t26_abort_no_en", en_cnt, snap);

        // Asynchronous reset in the middle of a game
        clear_obs();
        start_game(8, 1'b0);
        repeat (4) cycle();
        reset_ni = 1'b0;
        #1;
        chk("t27_rst_ready", ready_o, 0);
        chk("t27_rst_v", v_o, 0);
        chk("t27_rst_en", en_o, 0);
        chk("t27_rst_fd", frames_done_o, 0);
        repeat (2) cycle();
        reset_ni = 1'b1;
        cycle();
        chk("t27_rst_ready_back", ready_o, 1);

        // Enable low for 7 cycles during a gap
        clear_obs();
        start_game(6, 1'b0);
        for (int k = 0; k < 30 && en_cnt < 2; k++) cycle();
        chk("t27_reach2", en_cnt, 2);
        en_i = 1'b0;
        repeat (7) cycle();
        chk("t27_frozen_en", en_cnt, 2);
        en_i = 1'b1;
        wait_result("t27_result", 60);
        chk("t27_en_count", en_cnt, 6);
        chk("t27_fd", frames_done_o, 6);
        if (en_times.size() >= 3) chk("t27_freeze_spacing", en_times[2] - en_times[1], GAP + 1 + 7);
        for (int i = 3; i < en_times.size(); i++)
            chk("t27_resume_spacing", en_times[i] - en_times[i-1], GAP + 1);
        consume();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            en_i        = ($urandom_range(7) != 0);
            v_i         = ($urandom_range(2) == 0);
            frames_i    = W'($urandom_range(5));
            step_mode_i = 1'($urandom_range(1));
            step_i      = 1'($urandom_range(1));
            pause_i     = ($urandom_range(3) == 0);
            abort_i     = ($urandom_range(19) == 0);
            stable_i    = ($urandom_range(14) == 0);
            yumi_i      = ($urandom_range(2) == 0);
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
